// File: rtl/afu_rd_req_engine.sv
// Multi-channel CCI-P C0 read request engine: round-robin channel arbitration, aligned 1/2/4-CL
// burst splitting, outstanding-CL credit cap, and RX response routing. Optional AFU_RD_STATS_EN.
module afu_rd_req_engine #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned LEN_W           = 6,
    parameter int unsigned TAG_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 64,
    localparam int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       cor_rd_valid,
    input  logic [NUM_CH*42-1:0]    cor_rd_addr,
    input  logic [NUM_CH*LEN_W-1:0] cor_rd_len,
    output logic [NUM_CH-1:0]       cor_rd_ready,
    input  logic                    spl_tx_rd_almostfull,
    output logic                    afu_tx_rd_valid,
    output logic [41:0]             afu_tx_rd_addr,
    output logic [1:0]              afu_tx_rd_cl_len,
    output logic [15:0]             afu_tx_rd_mdata,
    input  logic                    spl_rx_rd_valid,
    input  logic [15:0]             spl_rx_rd_mdata,
    input  logic [1:0]              spl_rx_rd_cl_num,
    input  logic [511:0]            spl_rx_data,
    output logic [NUM_CH-1:0]       io_rx_rd_valid,
    output logic [1:0]              io_rx_cl_num,
    output logic [511:0]            io_rx_data,
    output logic [OUT_W-1:0]        io_outstanding
`ifdef AFU_RD_STATS_EN
    ,
    output logic [31:0]             stat_req_cnt,
    output logic [31:0]             stat_stall_cnt,
    output logic [31:0]             stat_rsp_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e              r_state, w_state_d;
    logic [CH_W-1:0]     r_rr, r_ch;
    logic [41:0]         r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [TAG_W-1:0]    r_tag;
    logic [OUT_W-1:0]    r_out;
    logic                r_tx_valid;
    logic [41:0]         r_tx_addr;
    logic [1:0]          r_tx_cl_len;
    logic [15:0]         r_tx_mdata;
    logic [NUM_CH-1:0]   r_rx_valid;
    logic [1:0]          r_rx_cl_num;
    logic [511:0]        r_rx_data;

    logic                w_grant_vld;
    logic [CH_W-1:0]     w_grant_ch;
    logic [CH_W-1:0]     w_scan;
    logic                w_accept;
    logic [LEN_W-1:0]    w_len_in;
    logic [2:0]          w_chunk;
    logic [1:0]          w_cl_len;
    logic                w_credit_ok;
    logic                w_issue;
    logic                w_last;
    logic [31:0]         w_out_sum;
    logic [31:0]         w_out_next;
    logic [CH_W-1:0]     w_rsp_ch;
    logic [NUM_CH-1:0]   w_rx_onehot;
    logic                w_unused_mdata;

    // Scan from highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_scan      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_scan = CH_W'((32'(r_rr) + 32'(i)) % NUM_CH);
            if (cor_rd_valid[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_scan;
            end
        end
    end

    // Ready is gated by reset so every output reads 0 while reset_n is low.
    assign w_accept = reset_n && (r_state == StIdle) && w_grant_vld;
    assign w_len_in = cor_rd_len[32'(w_grant_ch) * LEN_W +: LEN_W];

    always_comb begin
        cor_rd_ready = '0;
        if (w_accept) begin
            cor_rd_ready[w_grant_ch] = 1'b1;
        end
    end

    always_comb begin
        w_chunk  = 3'd1;
        w_cl_len = 2'd0;
        if (32'(r_rem) >= 32'd4 && r_addr[1:0] == 2'b00) begin
            w_chunk  = 3'd4;
            w_cl_len = 2'd3;
        end else if (32'(r_rem) >= 32'd2 && !r_addr[0]) begin
            w_chunk  = 3'd2;
            w_cl_len = 2'd1;
        end
    end

    assign w_credit_ok = (32'(r_out) + 32'(w_chunk)) <= MAX_OUTSTANDING;
    assign w_issue     = (r_state == StIssue) && !spl_tx_rd_almostfull && w_credit_ok;
    assign w_last      = 32'(r_rem) == 32'(w_chunk);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StIssue;
            StIssue: if (w_issue && w_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Issue and response fold into one update; a response never drives the count below zero.
    always_comb begin
        w_out_sum  = 32'(r_out) + (w_issue ? 32'(w_chunk) : 32'd0);
        w_out_next = w_out_sum;
        if (spl_rx_rd_valid && w_out_sum != 32'd0) begin
            w_out_next = w_out_sum - 32'd1;
        end
    end

    assign w_rsp_ch       = spl_rx_rd_mdata[TAG_W +: CH_W];
    assign w_unused_mdata = ^spl_rx_rd_mdata;

    always_comb begin
        w_rx_onehot = '0;
        if (spl_rx_rd_valid && 32'(w_rsp_ch) < NUM_CH) begin
            w_rx_onehot[w_rsp_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_rr        <= '0;
            r_ch        <= '0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_tag       <= '0;
            r_out       <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_cl_len <= '0;
            r_tx_mdata  <= '0;
            r_rx_valid  <= '0;
            r_rx_cl_num <= '0;
            r_rx_data   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_out      <= OUT_W'(w_out_next);
            r_tx_valid <= w_issue;
            r_rx_valid <= w_rx_onehot;
            if (w_accept) begin
                r_addr <= cor_rd_addr[32'(w_grant_ch) * 42 +: 42];
                r_rem  <= (w_len_in == '0) ? LEN_W'(1) : w_len_in;
                r_ch   <= w_grant_ch;
                r_rr   <= CH_W'((32'(w_grant_ch) + 32'd1) % NUM_CH);
            end
            if (w_issue) begin
                r_tx_addr   <= r_addr;
                r_tx_cl_len <= w_cl_len;
                r_tx_mdata  <= 16'({r_ch, r_tag});
                r_addr      <= r_addr + 42'(w_chunk);
                r_rem       <= r_rem - LEN_W'(w_chunk);
                r_tag       <= r_tag + 1'b1;
            end
            if (spl_rx_rd_valid) begin
                r_rx_cl_num <= spl_rx_rd_cl_num;
                r_rx_data   <= spl_rx_data;
            end
        end
    end

    assign afu_tx_rd_valid  = r_tx_valid;
    assign afu_tx_rd_addr   = r_tx_addr;
    assign afu_tx_rd_cl_len = r_tx_cl_len;
    assign afu_tx_rd_mdata  = r_tx_mdata;
    assign io_rx_rd_valid   = r_rx_valid;
    assign io_rx_cl_num     = r_rx_cl_num;
    assign io_rx_data       = r_rx_data;
    assign io_outstanding   = r_out;

`ifdef AFU_RD_STATS_EN
    logic [31:0] r_req_cnt, r_stall_cnt, r_rsp_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_cnt   <= '0;
            r_stall_cnt <= '0;
            r_rsp_cnt   <= '0;
        end else begin
            if (w_issue) r_req_cnt <= r_req_cnt + 32'd1;
            if (r_state == StIssue && !w_issue) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (spl_rx_rd_valid) r_rsp_cnt <= r_rsp_cnt + 32'd1;
        end
    end

    assign stat_req_cnt   = r_req_cnt;
    assign stat_stall_cnt = r_stall_cnt;
    assign stat_rsp_cnt   = r_rsp_cnt;
`endif

endmodule

// File: tb/tb_afu_rd_req_engine.sv
// Self-checking bench for afu_rd_req_engine: default instance plus a MAX_OUTSTANDING=4 instance.
module tb_afu_rd_req_engine;

    localparam int NCH   = 4;
    localparam int LEN_W = 6;

    typedef struct packed {
        logic [41:0] addr;
        logic [1:0]  cl_len;
        logic [15:0] mdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    logic [NCH-1:0]         cor_rd_valid;
    logic [NCH*42-1:0]      cor_rd_addr;
    logic [NCH*LEN_W-1:0]   cor_rd_len;
    logic [NCH-1:0]         cor_rd_ready;
    logic                   spl_tx_rd_almostfull;
    logic                   afu_tx_rd_valid;
    logic [41:0]            afu_tx_rd_addr;
    logic [1:0]             afu_tx_rd_cl_len;
    logic [15:0]            afu_tx_rd_mdata;
    logic                   spl_rx_rd_valid;
    logic [15:0]            spl_rx_rd_mdata;
    logic [1:0]             spl_rx_rd_cl_num;
    logic [511:0]           spl_rx_data;
    logic [NCH-1:0]         io_rx_rd_valid;
    logic [1:0]             io_rx_cl_num;
    logic [511:0]           io_rx_data;
    logic [6:0]             io_outstanding;

    logic [NCH-1:0]         b_valid;
    logic [NCH*42-1:0]      b_addr;
    logic [NCH*LEN_W-1:0]   b_len;
    logic [NCH-1:0]         b_ready;
    logic                   b_tx_valid;
    logic [41:0]            b_tx_addr;
    logic [1:0]             b_tx_cl_len;
    logic [15:0]            b_tx_mdata;
    logic                   b_rx_valid;
    logic [NCH-1:0]         b_io_rx_valid;
    logic [1:0]             b_io_cl_num;
    logic [511:0]           b_io_data;
    logic [2:0]             b_out;

`ifdef AFU_RD_STATS_EN
    logic [31:0] stat_req_cnt, stat_stall_cnt, stat_rsp_cnt;
    logic [31:0] b_stat_req, b_stat_stall, b_stat_rsp;
`endif

    afu_rd_req_engine #(
        .NUM_CH(4), .LEN_W(6), .TAG_W(8), .MAX_OUTSTANDING(64)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cor_rd_valid(cor_rd_valid), .cor_rd_addr(cor_rd_addr), .cor_rd_len(cor_rd_len),
        .cor_rd_ready(cor_rd_ready), .spl_tx_rd_almostfull(spl_tx_rd_almostfull),
        .afu_tx_rd_valid(afu_tx_rd_valid), .afu_tx_rd_addr(afu_tx_rd_addr),
        .afu_tx_rd_cl_len(afu_tx_rd_cl_len), .afu_tx_rd_mdata(afu_tx_rd_mdata),
        .spl_rx_rd_valid(spl_rx_rd_valid), .spl_rx_rd_mdata(spl_rx_rd_mdata),
        .spl_rx_rd_cl_num(spl_rx_rd_cl_num), .spl_rx_data(spl_rx_data),
        .io_rx_rd_valid(io_rx_rd_valid), .io_rx_cl_num(io_rx_cl_num), .io_rx_data(io_rx_data),
        .io_outstanding(io_outstanding)
`ifdef AFU_RD_STATS_EN
        , .stat_req_cnt(stat_req_cnt), .stat_stall_cnt(stat_stall_cnt),
        .stat_rsp_cnt(stat_rsp_cnt)
`endif
    );

    afu_rd_req_engine #(
        .NUM_CH(4), .LEN_W(6), .TAG_W(8), .MAX_OUTSTANDING(4)
    ) dut4 (
        .clk(clk), .reset_n(reset_n),
        .cor_rd_valid(b_valid), .cor_rd_addr(b_addr), .cor_rd_len(b_len),
        .cor_rd_ready(b_ready), .spl_tx_rd_almostfull(1'b0),
        .afu_tx_rd_valid(b_tx_valid), .afu_tx_rd_addr(b_tx_addr),
        .afu_tx_rd_cl_len(b_tx_cl_len), .afu_tx_rd_mdata(b_tx_mdata),
        .spl_rx_rd_valid(b_rx_valid), .spl_rx_rd_mdata(16'h0000),
        .spl_rx_rd_cl_num(2'b00), .spl_rx_data(512'd0),
        .io_rx_rd_valid(b_io_rx_valid), .io_rx_cl_num(b_io_cl_num), .io_rx_data(b_io_data),
        .io_outstanding(b_out)
`ifdef AFU_RD_STATS_EN
        , .stat_req_cnt(b_stat_req), .stat_stall_cnt(b_stat_stall), .stat_rsp_cnt(b_stat_rsp)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   m_tag, m_rr, m_out;
    req_t txq[$];
    req_t exp_q[$];

    always @(negedge clk) begin
        if (reset_n && afu_tx_rd_valid) begin
            req_t r;
            r.addr   = afu_tx_rd_addr;
            r.cl_len = afu_tx_rd_cl_len;
            r.mdata  = afu_tx_rd_mdata;
            txq.push_back(r);
        end
    end

    // Reference: split a request into aligned chunks from the splitting rules directly.
    task automatic model_req(input int ch, input logic [41:0] a, input int len);
        int          rem;
        int          c;
        logic [41:0] ad;
        req_t        r;
        rem = (len == 0) ? 1 : len;
        ad  = a;
        while (rem > 0) begin
            if (rem >= 4 && (ad % 4) == 0) c = 4;
            else if (rem >= 2 && (ad % 2) == 0) c = 2;
            else c = 1;
            r.addr   = ad;
            r.cl_len = (c == 4) ? 2'd3 : (c == 2) ? 2'd1 : 2'd0;
            r.mdata  = 16'((ch << 8) | (m_tag % 256));
            exp_q.push_back(r);
            ad    = ad + 42'(c);
            rem   = rem - c;
            m_tag = (m_tag + 1) % 256;
            m_out = m_out + c;
        end
        m_rr = (ch + 1) % NCH;
    endtask

    task automatic do_req(input int ch, input logic [41:0] a, input int len);
        bit ok;
        @(negedge clk);
        cor_rd_valid[ch] = 1'b1;
        cor_rd_addr[ch*42 +: 42] = a;
        cor_rd_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
        #1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cor_rd_ready[ch]) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout ch=%0d ready=%b required ready[%0d]=1", ch, cor_rd_ready, ch);
        end
        @(posedge clk);
        @(negedge clk);
        cor_rd_valid[ch] = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300; i++) begin
            if (txq.size() >= n) break;
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_rsp(input logic [15:0] md, input logic [1:0] cn, input logic [511:0] d);
        @(negedge clk);
        spl_rx_rd_valid  = 1'b1;
        spl_rx_rd_mdata  = md;
        spl_rx_rd_cl_num = cn;
        spl_rx_data      = d;
        @(negedge clk);
        spl_rx_rd_valid  = 1'b0;
        if (m_out > 0) m_out--;
    endtask

    task automatic drain();
        int n;
        n = m_out;
        for (int i = 0; i < n; i++) send_rsp(16'h0000, 2'd0, 512'd0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cor_rd_valid = '1;
        repeat (3) @(negedge clk);
        checks += 10;
        if (afu_tx_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", afu_tx_rd_valid); end
        if (afu_tx_rd_addr !== 42'd0) begin errors++; $display("FAIL rst_tx_addr got %h want 0", afu_tx_rd_addr); end
        if (afu_tx_rd_cl_len !== 2'd0) begin errors++; $display("FAIL rst_cl_len got %0d want 0", afu_tx_rd_cl_len); end
        if (afu_tx_rd_mdata !== 16'd0) begin errors++; $display("FAIL rst_mdata got %h want 0", afu_tx_rd_mdata); end
        if (cor_rd_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got %b want 0", cor_rd_ready); end
        if (io_rx_rd_valid !== 4'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", io_rx_rd_valid); end
        if (io_rx_cl_num !== 2'd0) begin errors++; $display("FAIL rst_rx_cl got %0d want 0", io_rx_cl_num); end
        if (io_rx_data !== 512'd0) begin errors++; $display("FAIL rst_rx_data got nonzero want 0"); end
        if (io_outstanding !== 7'd0) begin errors++; $display("FAIL rst_outst got %0d want 0", io_outstanding); end
        if (b_out !== 3'd0 || b_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_dut4 got out=%0d v=%b want 0", b_out, b_tx_valid); end
        cor_rd_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        m_tag = 0; m_rr = 0; m_out = 0;
    endtask

    task automatic test_single();
        logic [511:0] d;
        txq.delete(); exp_q.delete();
        model_req(1, 42'h100, 1);
        do_req(1, 42'h100, 1);
        checks++;
        if (afu_tx_rd_valid !== 1'b0) begin errors++; $display("FAIL single_early got valid=%b want 0", afu_tx_rd_valid); end
        @(negedge clk);
        checks += 4;
        if (afu_tx_rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", afu_tx_rd_valid); end
        if (afu_tx_rd_addr !== exp_q[0].addr) begin errors++; $display("FAIL single_addr got %h want %h", afu_tx_rd_addr, exp_q[0].addr); end
        if (afu_tx_rd_cl_len !== 2'd0) begin errors++; $display("FAIL single_cl_len got %0d want 0", afu_tx_rd_cl_len); end
        if (afu_tx_rd_mdata !== 16'h0100) begin errors++; $display("FAIL single_mdata got %h want 0100", afu_tx_rd_mdata); end
        @(negedge clk);
        checks += 3;
        if (afu_tx_rd_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", afu_tx_rd_valid); end
        if (afu_tx_rd_addr !== 42'h100) begin errors++; $display("FAIL single_hold got %h want 100", afu_tx_rd_addr); end
        if (io_outstanding !== 7'(m_out)) begin errors++; $display("FAIL single_outst got %0d want %0d", io_outstanding, m_out); end
        d = {16{$urandom}};
        send_rsp(16'h0100, 2'd2, d);
        checks += 4;
        if (io_rx_rd_valid !== 4'b0010) begin errors++; $display("FAIL single_rx_route got %b want 0010", io_rx_rd_valid); end
        if (io_rx_data !== d) begin errors++; $display("FAIL single_rx_data got %h want %h", io_rx_data[31:0], d[31:0]); end
        if (io_rx_cl_num !== 2'd2) begin errors++; $display("FAIL single_rx_cl got %0d want 2", io_rx_cl_num); end
        if (io_outstanding !== 7'(m_out)) begin errors++; $display("FAIL single_outst_dec got %0d want %0d", io_outstanding, m_out); end
    endtask

    task automatic test_burst();
        req_t g;
        txq.delete(); exp_q.delete();
        model_req(0, 42'h3, 7);
        do_req(0, 42'h3, 7);
        wait_tx(exp_q.size());
        checks++;
        if (txq.size() != exp_q.size()) begin errors++; $display("FAIL burst_count got %0d want %0d", txq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < txq.size()) ? txq[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL burst[%0d] got addr=%h len=%0d md=%h want addr=%h len=%0d md=%h", i,
                         g.addr, g.cl_len, g.mdata, exp_q[i].addr, exp_q[i].cl_len, exp_q[i].mdata);
            end
        end
        checks++;
        if (io_outstanding !== 7'(m_out)) begin errors++; $display("FAIL burst_outst got %0d want %0d", io_outstanding, m_out); end
        drain();
        checks++;
        if (io_outstanding !== 7'd0) begin errors++; $display("FAIL burst_drain got %0d want 0", io_outstanding); end
    endtask

    task automatic test_rr();
        req_t g;
        int   exp_ch;
        bit   ok;
        txq.delete(); exp_q.delete();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            cor_rd_addr[c*42 +: 42] = 42'h1000 + 42'(c * 16);
            cor_rd_len[c*LEN_W +: LEN_W] = 6'd1;
        end
        cor_rd_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            ok = 0;
            for (int t = 0; t < 20; t++) begin
                if (cor_rd_ready != '0) begin ok = 1; break; end
                @(negedge clk); #1;
            end
            exp_ch = m_rr;
            checks++;
            if (!ok || cor_rd_ready !== 4'(1 << exp_ch)) begin
                errors++;
                $display("FAIL rr_grant[%0d] got ready=%b want %b", k, cor_rd_ready, 4'(1 << exp_ch));
            end
            model_req(exp_ch, 42'h1000 + 42'(exp_ch * 16), 1);
            @(posedge clk);
            @(negedge clk);
        end
        cor_rd_valid = '0;
        wait_tx(5);
        for (int i = 0; i < 5; i++) begin
            g = (i < txq.size()) ? txq[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_req[%0d] got addr=%h md=%h want addr=%h md=%h", i, g.addr, g.mdata,
                         exp_q[i].addr, exp_q[i].mdata);
            end
        end
        drain();
    endtask

    task automatic test_almostfull();
        req_t g;
`ifdef AFU_RD_STATS_EN
        logic [31:0] stall0;
`endif
        txq.delete(); exp_q.delete();
        model_req(2, 42'h40, 16);
        do_req(2, 42'h40, 16);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (afu_tx_rd_valid) break;
        end
        spl_tx_rd_almostfull = 1'b1;
`ifdef AFU_RD_STATS_EN
        stall0 = stat_stall_cnt;
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (afu_tx_rd_valid !== 1'b0) begin errors++; $display("FAIL af_hold[%0d] got valid=%b want 0", k, afu_tx_rd_valid); end
        end
        spl_tx_rd_almostfull = 1'b0;
        wait_tx(exp_q.size());
        checks++;
        if (txq.size() != exp_q.size()) begin errors++; $display("FAIL af_count got %0d want %0d", txq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < txq.size()) ? txq[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL af_req[%0d] got addr=%h len=%0d want addr=%h len=%0d", i, g.addr, g.cl_len,
                         exp_q[i].addr, exp_q[i].cl_len);
            end
        end
`ifdef AFU_RD_STATS_EN
        checks++;
        if (stat_stall_cnt - stall0 !== 32'd5) begin errors++; $display("FAIL af_stall_cnt got %0d want 5", stat_stall_cnt - stall0); end
`endif
        drain();
    endtask

    task automatic test_credit();
        bit ok;
        @(negedge clk);
        b_valid[0] = 1'b1;
        b_addr[41:0] = 42'd0;
        b_len[5:0] = 6'd8;
        #1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            if (b_ready[0]) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL credit_accept got ready=%b want 0001", b_ready); end
        @(posedge clk);
        @(negedge clk);
        b_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (b_tx_valid !== 1'b1 || b_tx_addr !== 42'd0 || b_tx_cl_len !== 2'd3 || b_out !== 3'd4) begin
            errors++;
            $display("FAIL credit_first got v=%b a=%h l=%0d out=%0d want v=1 a=0 l=3 out=4",
                     b_tx_valid, b_tx_addr, b_tx_cl_len, b_out);
        end
        b_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_tx_valid !== 1'b0 || b_out !== 3'(3 - i)) begin
                errors++;
                $display("FAIL credit_stall[%0d] got v=%b out=%0d want v=0 out=%0d", i, b_tx_valid, b_out, 3 - i);
            end
        end
        @(negedge clk);
        b_rx_valid = 1'b0;
        checks++;
        if (b_tx_valid !== 1'b1 || b_tx_addr !== 42'd4 || b_tx_mdata !== 16'h0001 || b_out !== 3'd3) begin
            errors++;
            $display("FAIL credit_net got v=%b a=%h md=%h out=%0d want v=1 a=4 md=0001 out=3",
                     b_tx_valid, b_tx_addr, b_tx_mdata, b_out);
        end
        b_rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        b_rx_valid = 1'b0;
        checks++;
        if (b_out !== 3'd0) begin errors++; $display("FAIL credit_drain got %0d want 0", b_out); end
    endtask

    task automatic test_rx_route();
        logic [511:0] d;
        int           ch;
        d = {16{$urandom}};
        send_rsp(16'h0205, 2'd1, d);
        checks += 4;
        if (io_rx_rd_valid !== 4'b0100) begin errors++; $display("FAIL rx_0205 got %b want 0100", io_rx_rd_valid); end
        if (io_rx_data !== d) begin errors++; $display("FAIL rx_0205_data got %h want %h", io_rx_data[31:0], d[31:0]); end
        if (io_rx_cl_num !== 2'd1) begin errors++; $display("FAIL rx_0205_cl got %0d want 1", io_rx_cl_num); end
        if (io_outstanding !== 7'd0) begin errors++; $display("FAIL rx_saturate got %0d want 0", io_outstanding); end
        for (int k = 0; k < 5; k++) begin
            ch = int'($urandom_range(0, 3));
            d  = {16{$urandom}};
            send_rsp(16'((ch << 8) | int'($urandom_range(0, 255))), 2'(k), d);
            checks++;
            if (io_rx_rd_valid !== 4'(1 << ch) || io_rx_data !== d) begin
                errors++;
                $display("FAIL rx_rand[%0d] got %b want %b", k, io_rx_rd_valid, 4'(1 << ch));
            end
        end
        @(negedge clk);
        checks++;
        if (io_rx_rd_valid !== 4'b0) begin errors++; $display("FAIL rx_pulse got %b want 0", io_rx_rd_valid); end
    endtask

    task automatic test_random();
        req_t         g;
        int           ch, len, n;
        logic [41:0]  a;
        logic [511:0] d;
        for (int it = 0; it < 8; it++) begin
            txq.delete(); exp_q.delete();
            ch  = int'($urandom_range(0, 3));
            len = int'($urandom_range(0, 12));
            a   = {10'd0, 32'($urandom)};
            model_req(ch, a, len);
            do_req(ch, a, len);
            wait_tx(exp_q.size());
            checks++;
            if (txq.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", it, txq.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (i < txq.size()) ? txq[i] : '0;
                checks++;
                if (g !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_req[%0d.%0d] got a=%h l=%0d md=%h want a=%h l=%0d md=%h", it, i,
                             g.addr, g.cl_len, g.mdata, exp_q[i].addr, exp_q[i].cl_len, exp_q[i].mdata);
                end
            end
            checks++;
            if (io_outstanding !== 7'(m_out)) begin errors++; $display("FAIL rnd_outst[%0d] got %0d want %0d", it, io_outstanding, m_out); end
            n = m_out;
            for (int j = 0; j < n; j++) begin
                d = {16{$urandom}};
                send_rsp(exp_q[0].mdata, 2'(j), d);
                checks++;
                if (io_rx_rd_valid !== 4'(1 << ch) || io_rx_data !== d) begin
                    errors++;
                    $display("FAIL rnd_rsp[%0d.%0d] got %b want %b", it, j, io_rx_rd_valid, 4'(1 << ch));
                end
            end
            checks++;
            if (io_outstanding !== 7'd0) begin errors++; $display("FAIL rnd_drain[%0d] got %0d want 0", it, io_outstanding); end
        end
    endtask

    task automatic test_reset_midburst();
        txq.delete(); exp_q.delete();
        do_req(3, 42'd0, 32);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (afu_tx_rd_valid) break;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (afu_tx_rd_valid !== 1'b0 || afu_tx_rd_addr !== 42'd0 || afu_tx_rd_cl_len !== 2'd0 ||
            afu_tx_rd_mdata !== 16'd0 || io_outstanding !== 7'd0 || io_rx_rd_valid !== 4'd0 ||
            cor_rd_ready !== 4'd0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b a=%h md=%h out=%0d want all 0", afu_tx_rd_valid,
                     afu_tx_rd_addr, afu_tx_rd_mdata, io_outstanding);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_tag = 0; m_rr = 0; m_out = 0;
        txq.delete();
        repeat (12) @(negedge clk);
        checks++;
        if (txq.size() != 0 || io_outstanding !== 7'd0) begin
            errors++;
            $display("FAIL midrst_abort got tx=%0d out=%0d want 0 0", txq.size(), io_outstanding);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cor_rd_valid = '0; cor_rd_addr = '0; cor_rd_len = '0;
        spl_tx_rd_almostfull = 1'b0;
        spl_rx_rd_valid = 1'b0; spl_rx_rd_mdata = '0; spl_rx_rd_cl_num = '0; spl_rx_data = '0;
        b_valid = '0; b_addr = '0; b_len = '0; b_rx_valid = 1'b0;
        m_tag = 0; m_rr = 0; m_out = 0;
        test_reset();
        test_single();
        test_burst();
        test_rr();
        test_almostfull();
        test_credit();
        test_rx_route();
        test_random();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
